// File: rtl/ex_stage_mc_if.sv
// Execute-stage bus: ID/EX operands and control in, EX results and the stall request out.
// The master side is the pipeline control; the slave side is the execute stage.
interface ex_stage_mc_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              valid_e;
  logic              flush_e;
  logic [3:0]        alu_control_e;
  logic              alu_src_e;
  logic              reg_dst_e;
  logic [WIDTH-1:0]  srca_e;
  logic [WIDTH-1:0]  srcb_e;
  logic [WIDTH-1:0]  sign_imm_e;
  logic [REG_AW-1:0] rt_e;
  logic [REG_AW-1:0] rd_e;
  logic [WIDTH-1:0]  result_w;
  logic [WIDTH-1:0]  alu_out_m;
  logic [1:0]        forward_a_e;
  logic [1:0]        forward_b_e;
  logic [WIDTH-1:0]  alu_out_e;
  logic [WIDTH-1:0]  write_data_e;
  logic [REG_AW-1:0] write_reg_e;
  logic              zero_e;
  logic              busy_e;

  modport master (
    output valid_e, flush_e, alu_control_e, alu_src_e, reg_dst_e,
           srca_e, srcb_e, sign_imm_e, rt_e, rd_e, result_w, alu_out_m,
           forward_a_e, forward_b_e,
    input  alu_out_e, write_data_e, write_reg_e, zero_e, busy_e
  );

  modport slave (
    input  valid_e, flush_e, alu_control_e, alu_src_e, reg_dst_e,
           srca_e, srcb_e, sign_imm_e, rt_e, rd_e, result_w, alu_out_m,
           forward_a_e, forward_b_e,
    output alu_out_e, write_data_e, write_reg_e, zero_e, busy_e
  );
endinterface

// File: rtl/ex_stage_mc.sv
// MIPS execute stage: forwarding, ALU, iterative unsigned mul/div with HI/LO.
// Latency: ALU/forwarding 0 cycles; MULTU/DIVU stall WIDTH+1 cycles via busy_e.
module ex_stage_mc #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         reset,
  ex_stage_mc_if.slave ex
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_res;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] md_m;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH:0]   md_hi;
  logic             md_div;
  logic [CW-1:0]    cnt;

  logic             is_md, launch, step_en, busy;
  logic [WIDTH:0]   mul_sum, mul_acc, div_shift, div_trial;
  logic             div_ge;
  logic [WIDTH:0]   nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  always_comb begin
    src_a = ex.srca_e;
    case (ex.forward_a_e)
      2'b01:   src_a = ex.result_w;
      2'b10:   src_a = ex.alu_out_m;
      default: src_a = ex.srca_e;
    endcase
    fwd_b = ex.srcb_e;
    case (ex.forward_b_e)
      2'b01:   fwd_b = ex.result_w;
      2'b10:   fwd_b = ex.alu_out_m;
      default: fwd_b = ex.srcb_e;
    endcase
    src_b = ex.alu_src_e ? ex.sign_imm_e : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (ex.alu_control_e)
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_ADD:  alu_res = src_a + src_b;
      OP_NOR:  alu_res = ~(src_a | src_b);
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  assign ex.alu_out_e    = alu_res;
  assign ex.write_data_e = fwd_b;
  assign ex.write_reg_e  = ex.reg_dst_e ? ex.rd_e : ex.rt_e;
  assign ex.zero_e       = (alu_res == '0);
  assign ex.busy_e       = busy;

  // One iteration: shift-add for multiply, restoring subtract for divide.
  // A zero divisor always "fits", so the quotient saturates to all ones and the remainder ends up as A.
  always_comb begin
    mul_sum   = md_hi + {1'b0, md_m};
    mul_acc   = md_lo[0] ? mul_sum : md_hi;
    div_shift = {md_hi[WIDTH-1:0], md_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, md_m};
    div_ge    = ~div_trial[WIDTH];
    if (md_div) begin
      nxt_hi = div_ge ? div_trial : div_shift;
      nxt_lo = {md_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = {1'b0, mul_acc[WIDTH:1]};
      nxt_lo = {mul_acc[0], md_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (ex.flush_e) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    is_md   = (ex.alu_control_e == OP_MULTU) || (ex.alu_control_e == OP_DIVU);
    launch  = (state == IDLE) && ex.valid_e && is_md && !ex.flush_e;
    step_en = (state == RUN) && !ex.flush_e;
    busy    = reset && (launch || step_en);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi     <= '0;
      lo     <= '0;
      md_m   <= '0;
      md_lo  <= '0;
      md_hi  <= '0;
      md_div <= 1'b0;
      cnt    <= '0;
    end else if (launch) begin
      md_div <= (ex.alu_control_e == OP_DIVU);
      md_m   <= (ex.alu_control_e == OP_DIVU) ? fwd_b : src_a;
      md_lo  <= (ex.alu_control_e == OP_DIVU) ? src_a : fwd_b;
      md_hi  <= '0;
      cnt    <= CW'(WIDTH-1);
    end else if (step_en) begin
      md_hi <= nxt_hi;
      md_lo <= nxt_lo;
      cnt   <= cnt - 1'b1;
      if (cnt == '0) begin
        hi <= nxt_hi[WIDTH-1:0];
        lo <= nxt_lo;
      end
    end
  end

endmodule
